operand_forward_stage: RTL and testbench
========================================

Name: operand_forward_stage

Overview:
- ID/EX pipeline stage directly downstream of the register file. Once per cycle it captures the three register-file read ports (PA/PB/PC) and the decoded control for one instruction, and presents them to the EX stage.
- Before capture, it substitutes in-flight results from the EX, MEM and WB stages.
- Detects load-use hazards, stalls decode for one cycle and inserts a bubble.
- Handles branch flush and keeps a saturating stall counter for performance debug.

Parameters:
- CTRL_W, 8, width of the opaque decoded-control bundle carried into EX
- CNT_W, 16, width of the saturating stall counter

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  asynchronous active-high reset
- ID_VALID  in  1  decode holds a real instruction
- ID_RA, ID_RB, ID_RC  in  4 each  source register indices driven to the register file
- ID_USE_A, ID_USE_B, ID_USE_C  in  1 each  instruction actually reads that source
- PA, PB, PC  in  32 each  register-file read data for RA/RB/RC
- ID_RD  in  4  destination register index
- ID_LE  in  1  instruction writes ID_RD
- ID_LOAD  in  1  instruction is a memory load
- ID_CTRL  in  CTRL_W  decoded control bundle
- EX_RESULT  in  32  ALU result of the instruction currently held in this stage
- MEM_RD, MEM_LE, MEM_RESULT  in  4/1/32  MEM-stage destination, write enable, result (load data for loads)
- WB_RD, WB_LE, WB_RESULT  in  4/1/32  WB-stage destination, write enable, data (same values as RW/LE/PW to the register file)
- FLUSH  in  1  discard the decode-stage instruction (taken branch)
- EX_VALID  out  1  EX holds a real instruction
- EX_OPA, EX_OPB, EX_OPC  out  32 each  forwarded operands
- EX_RD, EX_LE, EX_LOAD  out  4/1/1  registered destination info
- EX_CTRL  out  CTRL_W  registered control
- STALL  out  1  combinational; freeze PC and decode this cycle
- STALL_CNT  out  CNT_W  count of stall cycles since reset

Behaviour:
- Reset (asynchronous, immediate): every registered output is 0, including EX_VALID, EX_LE, EX_LOAD, operands, EX_RD, EX_CTRL and STALL_CNT. Reset mid-stall drops the bubble and the counter.
- Forwarding, per source s (A/B/C, index ID_Rs, port value Ps):
  - No forwarding when ID_USE_s = 0 or ID_Rs = 15. Register 15 is the program counter and always comes from the port.
  - Priority 1: EX_VALID & EX_LE & !EX_LOAD & EX_RD == ID_Rs → EX_RESULT.
  - Priority 2: MEM_LE & MEM_RD == ID_Rs → MEM_RESULT.
  - Priority 3: WB_LE & WB_RD == ID_Rs → WB_RESULT. This covers the write landing in the same cycle as the read.
  - Otherwise → Ps.
  - Forwarding is combinational; the result is registered at the edge, giving a latency of 1 cycle from ID to EX_OP*.
- Load-use hazard:
  - Condition: hazard_s = ID_VALID & ID_USE_s & ID_Rs != 15 & EX_VALID & EX_LOAD & EX_LE & EX_RD == ID_Rs.
  - STALL = !FLUSH & (hazard_A | hazard_B | hazard_C).
  - When STALL = 1, the next edge loads a bubble. Decode holds its instruction.
  - On the following cycle the load sits in MEM and its data forwards via MEM_RESULT, so STALL deasserts and the instruction advances. A stall lasts exactly 1 cycle per hazard.
- Bubble definition: EX_VALID = 0, EX_LE = 0, EX_LOAD = 0. EX_OP*, EX_RD and EX_CTRL are don't-care; they are loaded with 0.
- Next-state priority at each edge: RESET > FLUSH (bubble) > STALL (bubble) > !ID_VALID (bubble) > normal capture of all ID fields plus forwarded operands.
- Simultaneous FLUSH and hazard: flush wins, STALL = 0, and the counter does not increment.
- STALL_CNT: increments on every edge where STALL = 1. It saturates at all-ones and does not wrap.
- No back-pressure from EX: this stage always accepts.

Test Plan:
- Reset mid-stream: assert RESET with EX_VALID = 1 and STALL_CNT = 5 → all outputs 0 immediately, before any clock edge.
- EX forward: capture ADD R3 (EX_LE = 1, EX_LOAD = 0, EX_RESULT = 0x11); next ID reads RA = 3, PA = 0xDEAD, MEM_RD = 3, MEM_LE = 1, MEM_RESULT = 0x22 → EX_OPA = 0x11, since EX has priority over MEM.
- WB forward and R15 exclusion: WB_RD = 7, WB_LE = 1, WB_RESULT = 0xCAFE, RB = 7, PB = 0 → EX_OPB = 0xCAFE. Then with RC = 15, WB_RD = 15, WB_LE = 1, PC = 0x100 → EX_OPC = 0x100.
- Load-use: LDR R2 in EX, ID uses RA = 2 → STALL = 1 for one cycle, next EX_VALID = 0, STALL_CNT = 1. Next cycle MEM_RD = 2, MEM_LE = 1, MEM_RESULT = 0x55 → STALL = 0, EX_OPA = 0x55, EX_VALID = 1.
- Flush over hazard: same load-use setup plus FLUSH = 1 → STALL = 0, bubble captured, STALL_CNT unchanged.
- Counter saturation: CNT_W = 4, force 20 consecutive hazard cycles → STALL_CNT stops at 0xF.

Source files
------------

// File: rtl/operand_forward_stage.sv
// ID/EX pipeline register with EX/MEM/WB operand forwarding, load-use stall
// detection, branch flush and a saturating stall counter.
module operand_forward_stage #(
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [3:0]        id_ra,
    input  logic [3:0]        id_rb,
    input  logic [3:0]        id_rc,
    input  logic              id_use_a,
    input  logic              id_use_b,
    input  logic              id_use_c,
    input  logic [31:0]       pa,
    input  logic [31:0]       pb,
    input  logic [31:0]       pc,
    input  logic [3:0]        id_rd,
    input  logic              id_le,
    input  logic              id_load,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [31:0]       ex_result,
    input  logic [3:0]        mem_rd,
    input  logic              mem_le,
    input  logic [31:0]       mem_result,
    input  logic [3:0]        wb_rd,
    input  logic              wb_le,
    input  logic [31:0]       wb_result,
    input  logic              flush,
    output logic              ex_valid,
    output logic [31:0]       ex_opa,
    output logic [31:0]       ex_opb,
    output logic [31:0]       ex_opc,
    output logic [3:0]        ex_rd,
    output logic              ex_le,
    output logic              ex_load,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              ex_valid_reg;
    logic [2:0][31:0]  ex_op_reg;
    logic [3:0]        ex_rd_reg;
    logic              ex_le_reg;
    logic              ex_load_reg;
    logic [CTRL_W-1:0] ex_ctrl_reg;
    logic [CNT_W-1:0]  stall_cnt_reg;

    logic [2:0][3:0]   src_r;
    logic [2:0]        src_use;
    logic [2:0][31:0]  src_p;
    logic [2:0][31:0]  fwd_op;
    logic [2:0]        hazard;
    logic              capture;

    assign src_r   = {id_rc, id_rb, id_ra};
    assign src_use = {id_use_c, id_use_b, id_use_a};
    assign src_p   = {pc, pb, pa};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_src
            logic fwd_en;
            logic ex_hit;
            logic mem_hit;
            logic wb_hit;

            // R15 is the PC and is never forwarded.
            assign fwd_en  = src_use[gi] && (src_r[gi] != 4'd15);
            assign ex_hit  = ex_valid_reg && ex_le_reg && !ex_load_reg && (ex_rd_reg == src_r[gi]);
            assign mem_hit = mem_le && (mem_rd == src_r[gi]);
            assign wb_hit  = wb_le && (wb_rd == src_r[gi]);

            assign fwd_op[gi] = !fwd_en ? src_p[gi]  :
                                ex_hit  ? ex_result  :
                                mem_hit ? mem_result :
                                wb_hit  ? wb_result  :
                                          src_p[gi];

            // Load data is not available until MEM, so a load in EX forces a bubble.
            assign hazard[gi] = id_valid && fwd_en && ex_valid_reg && ex_load_reg &&
                                ex_le_reg && (ex_rd_reg == src_r[gi]);
        end
    endgenerate

    assign stall   = !flush && (|hazard);
    assign capture = !flush && !stall && id_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_reg  <= 1'b0;
            ex_op_reg     <= '0;
            ex_rd_reg     <= '0;
            ex_le_reg     <= 1'b0;
            ex_load_reg   <= 1'b0;
            ex_ctrl_reg   <= '0;
            stall_cnt_reg <= '0;
        end else begin
            ex_valid_reg <= capture;
            ex_le_reg    <= capture && id_le;
            ex_load_reg  <= capture && id_load;
            ex_rd_reg    <= capture ? id_rd   : 4'd0;
            ex_ctrl_reg  <= capture ? id_ctrl : '0;
            ex_op_reg    <= capture ? fwd_op  : '0;
            if (stall && (stall_cnt_reg != {CNT_W{1'b1}})) begin
                stall_cnt_reg <= stall_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign ex_valid  = ex_valid_reg;
    assign ex_opa    = ex_op_reg[0];
    assign ex_opb    = ex_op_reg[1];
    assign ex_opc    = ex_op_reg[2];
    assign ex_rd     = ex_rd_reg;
    assign ex_le     = ex_le_reg;
    assign ex_load   = ex_load_reg;
    assign ex_ctrl   = ex_ctrl_reg;
    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_operand_forward_stage.sv
// Directed and randomized checks of operand_forward_stage against a
// behavioural pipeline model kept in the bench.
module tb_operand_forward_stage;

    localparam int CTRL_W = 8;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              id_valid;
    logic [3:0]        id_ra, id_rb, id_rc;
    logic              id_use_a, id_use_b, id_use_c;
    logic [31:0]       pa, pb, pc;
    logic [3:0]        id_rd;
    logic              id_le, id_load;
    logic [CTRL_W-1:0] id_ctrl;
    logic [31:0]       ex_result;
    logic [3:0]        mem_rd;
    logic              mem_le;
    logic [31:0]       mem_result;
    logic [3:0]        wb_rd;
    logic              wb_le;
    logic [31:0]       wb_result;
    logic              flush;
    logic              ex_valid;
    logic [31:0]       ex_opa, ex_opb, ex_opc;
    logic [3:0]        ex_rd;
    logic              ex_le, ex_load;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              stall;
    logic [CNT_W-1:0]  stall_cnt;

    int compared   = 0;
    int mismatched = 0;

    // Model of what EX should hold, and the expected stall count.
    logic              m_valid, m_le, m_load;
    logic [3:0]        m_rd;
    logic [CTRL_W-1:0] m_ctrl;
    logic [31:0]       m_op [3];
    int                m_cnt;

    operand_forward_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_ra(id_ra), .id_rb(id_rb), .id_rc(id_rc),
        .id_use_a(id_use_a), .id_use_b(id_use_b), .id_use_c(id_use_c),
        .pa(pa), .pb(pb), .pc(pc),
        .id_rd(id_rd), .id_le(id_le), .id_load(id_load), .id_ctrl(id_ctrl),
        .ex_result(ex_result),
        .mem_rd(mem_rd), .mem_le(mem_le), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_le(wb_le), .wb_result(wb_result),
        .flush(flush),
        .ex_valid(ex_valid), .ex_opa(ex_opa), .ex_opb(ex_opb), .ex_opc(ex_opc),
        .ex_rd(ex_rd), .ex_le(ex_le), .ex_load(ex_load), .ex_ctrl(ex_ctrl),
        .stall(stall), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".ex_valid"}, {31'b0, ex_valid}, {31'b0, m_valid});
        chk({tag, ".ex_le"},    {31'b0, ex_le},    {31'b0, m_le});
        chk({tag, ".ex_load"},  {31'b0, ex_load},  {31'b0, m_load});
        chk({tag, ".ex_rd"},    {28'b0, ex_rd},    {28'b0, m_rd});
        chk({tag, ".ex_ctrl"},  {24'b0, ex_ctrl},  {24'b0, m_ctrl});
        chk({tag, ".ex_opa"},   ex_opa, m_op[0]);
        chk({tag, ".ex_opb"},   ex_opb, m_op[1]);
        chk({tag, ".ex_opc"},   ex_opc, m_op[2]);
        chk({tag, ".stall_cnt"}, {28'b0, stall_cnt}, 32'(m_cnt));
    endtask

    // Start from the register file value and let successively younger
    // producers overwrite it: WB, then MEM, then a non-load in EX.
    function automatic logic [31:0] exp_op(input logic use_s, input logic [3:0] r,
                                           input logic [31:0] p);
        logic [31:0] v;
        v = p;
        if (use_s && r != 4'd15) begin
            if (wb_le && wb_rd == r)   v = wb_result;
            if (mem_le && mem_rd == r) v = mem_result;
            if (m_valid && m_le && !m_load && m_rd == r) v = ex_result;
        end
        return v;
    endfunction

    function automatic logic load_use(input logic use_s, input logic [3:0] r);
        return id_valid && use_s && r != 4'd15 && m_valid && m_load && m_le && m_rd == r;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_le = 0; m_load = 0; m_rd = 0; m_ctrl = 0;
        for (int i = 0; i < 3; i++) m_op[i] = 0;
        m_cnt = 0;
    endtask

    task automatic set_idle();
        id_valid = 0; id_ra = 0; id_rb = 0; id_rc = 0;
        id_use_a = 0; id_use_b = 0; id_use_c = 0;
        pa = 0; pb = 0; pc = 0; id_rd = 0; id_le = 0; id_load = 0; id_ctrl = 0;
        ex_result = 0; mem_rd = 0; mem_le = 0; mem_result = 0;
        wb_rd = 0; wb_le = 0; wb_result = 0; flush = 0;
    endtask

    // Checks STALL before the edge, then the registered outputs after it.
    task automatic cycle(input string tag);
        logic [31:0] n_op [3];
        logic exp_stall, cap;
        #1;
        exp_stall = !flush && (load_use(id_use_a, id_ra) || load_use(id_use_b, id_rb) ||
                               load_use(id_use_c, id_rc));
        chk({tag, ".stall"}, {31'b0, stall}, {31'b0, exp_stall});
        n_op[0] = exp_op(id_use_a, id_ra, pa);
        n_op[1] = exp_op(id_use_b, id_rb, pb);
        n_op[2] = exp_op(id_use_c, id_rc, pc);
        cap = !flush && !exp_stall && id_valid;
        @(posedge clk);
        #1;
        m_valid = cap;
        m_le    = cap && id_le;
        m_load  = cap && id_load;
        m_rd    = cap ? id_rd : 4'd0;
        m_ctrl  = cap ? id_ctrl : '0;
        for (int i = 0; i < 3; i++) m_op[i] = cap ? n_op[i] : 32'd0;
        if (exp_stall && m_cnt < 15) m_cnt++;
        chk_all(tag);
    endtask

    task automatic do_hazard(input string tag);
        set_idle();
        id_valid = 1; id_rd = 4'd2; id_le = 1; id_load = 1;
        cycle({tag, ".ld"});
        set_idle();
        id_valid = 1; id_ra = 4'd2; id_use_a = 1; id_rd = 4'd9; id_le = 1;
        cycle({tag, ".use"});
    endtask

    function automatic logic [3:0] rand_reg();
        return ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
    endfunction

    initial begin
        set_idle();
        model_reset();
        reset = 1;
        #12;
        chk_all("por");
        reset = 0;
        @(posedge clk);
        #1;

        // EX result has priority over MEM.
        id_valid = 1; id_rd = 4'd3; id_le = 1; id_ctrl = 8'hA5;
        cycle("add_r3");
        set_idle();
        id_valid = 1; id_ra = 4'd3; id_use_a = 1; pa = 32'hDEAD;
        mem_rd = 4'd3; mem_le = 1; mem_result = 32'h22; ex_result = 32'h11; id_rd = 4'd3;
        cycle("ex_fwd");
        chk("ex_fwd.const", ex_opa, 32'h11);

        // WB forward, then R15 always from the port.
        set_idle();
        id_valid = 1; id_rb = 4'd7; id_use_b = 1; pb = 32'h0;
        wb_rd = 4'd7; wb_le = 1; wb_result = 32'hCAFE;
        cycle("wb_fwd");
        chk("wb_fwd.const", ex_opb, 32'hCAFE);
        set_idle();
        id_valid = 1; id_rc = 4'd15; id_use_c = 1; pc = 32'h100;
        wb_rd = 4'd15; wb_le = 1; wb_result = 32'hBAD;
        cycle("r15");
        chk("r15.const", ex_opc, 32'h100);

        // Load-use: one bubble, then MEM forwards the load data.
        set_idle();
        id_valid = 1; id_rd = 4'd2; id_le = 1; id_load = 1;
        cycle("ldr_r2");
        set_idle();
        id_valid = 1; id_ra = 4'd2; id_use_a = 1; id_rd = 4'd5; id_le = 1;
        #1 chk("lu.stall_const", {31'b0, stall}, 32'd1);
        cycle("lu_bubble");
        chk("lu.valid_const", {31'b0, ex_valid}, 32'd0);
        chk("lu.cnt_const", {28'b0, stall_cnt}, 32'd1);
        mem_rd = 4'd2; mem_le = 1; mem_result = 32'h55;
        cycle("lu_go");
        chk("lu.opa_const", ex_opa, 32'h55);
        chk("lu.valid_go", {31'b0, ex_valid}, 32'd1);

        // Flush beats a simultaneous hazard.
        set_idle();
        id_valid = 1; id_rd = 4'd2; id_le = 1; id_load = 1;
        cycle("ldr_r2b");
        set_idle();
        id_valid = 1; id_ra = 4'd2; id_use_a = 1; flush = 1;
        #1 chk("flush.stall_const", {31'b0, stall}, 32'd0);
        cycle("flush");
        chk("flush.cnt_const", {28'b0, stall_cnt}, 32'd1);

        // Bring the counter to 5 with a valid instruction in EX, then reset asynchronously.
        for (int i = 0; i < 4; i++) do_hazard($sformatf("pre_rst%0d", i));
        set_idle();
        id_valid = 1; id_rd = 4'd4; id_le = 1; id_ctrl = 8'h3C;
        cycle("pre_rst_cap");
        chk("pre_rst.cnt", {28'b0, stall_cnt}, 32'd5);
        chk("pre_rst.valid", {31'b0, ex_valid}, 32'd1);
        #2 reset = 1;
        model_reset();
        #1 chk_all("async_rst");
        #1 reset = 0;
        set_idle();
        cycle("post_rst");

        // Saturation of the 4-bit counter.
        for (int i = 0; i < 20; i++) do_hazard($sformatf("sat%0d", i));
        chk("sat.cnt_const", {28'b0, stall_cnt}, 32'hF);

        // Randomized traffic with forwarding-friendly register choices.
        for (int i = 0; i < 400; i++) begin
            id_valid   = ($urandom_range(0, 9) != 0);
            id_ra      = rand_reg(); id_rb = rand_reg(); id_rc = rand_reg();
            id_use_a   = 1'($urandom); id_use_b = 1'($urandom); id_use_c = 1'($urandom);
            pa         = $urandom; pb = $urandom; pc = $urandom;
            id_rd      = rand_reg();
            id_le      = 1'($urandom);
            id_load    = ($urandom_range(0, 2) == 0);
            id_ctrl    = 8'($urandom);
            ex_result  = $urandom;
            mem_rd     = rand_reg(); mem_le = 1'($urandom); mem_result = $urandom;
            wb_rd      = rand_reg(); wb_le = 1'($urandom);  wb_result  = $urandom;
            flush      = ($urandom_range(0, 9) == 0);
            cycle($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
